// File: rtl/alu2_pkg.sv
// Shared op encodings, FSM state type and helpers for the alu2 sequencer.
package alu2_pkg;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_AND = 5'b00100;
   localparam logic [4:0] OP_ORR = 5'b01000;
   localparam logic [4:0] OP_EOR = 5'b10000;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != 5'b00000) && ((v & (v - 5'b00001)) == 5'b00000);
   endfunction

endpackage

// File: rtl/alu2.sv
// Combinational 2-bit ALU slice driven one digit at a time by alu2_seq.
module alu2
   import alu2_pkg::*;
(
   input  logic [4:0] what_op,
   input  logic [1:0] operand0,
   input  logic [1:0] operand1,
   input  logic       carry_in,
   output logic [1:0] result,
   output logic       carry_out
);

   // Decode the one-hot op into a digit result and carry.
   always_comb begin
      result    = 2'b00;
      carry_out = 1'b0;
      case (what_op)
         OP_ADD: {carry_out, result} = {1'b0, operand0} + {1'b0, operand1} + {2'b00, carry_in};
         // Per-digit two's-complement negation; only correct for a single digit.
         OP_SUB: {carry_out, result} = {1'b0, operand0} + {1'b0, ~operand1} + 3'b001;
         OP_AND: result = operand0 & operand1;
         OP_ORR: result = operand0 | operand1;
         OP_EOR: result = operand0 ^ operand1;
         default: begin
            result    = 2'b00;
            carry_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu2_seq.sv
// Multi-cycle sequencer: computes WIDTH-bit ops through an external 2-bit
// slice, least significant digit first, chaining carry between digits.
module alu2_seq
   import alu2_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             rx_clk,
   input  logic             rx_reset,
   input  logic             rx_start,
   input  logic [4:0]       rx_what_op,
   input  logic [WIDTH-1:0] rx_operand0,
   input  logic [WIDTH-1:0] rx_operand1,
   input  logic             rx_carryflag,
   output logic             tx_ready,
   output logic             tx_done,
   output logic             tx_error,
   output logic [WIDTH-1:0] tx_result,
   output logic             tx_carryflag,
   output logic             tx_zeroflag,
   output logic             tx_signflag,
   output logic [4:0]       tx_slice_what_op,
   output logic [1:0]       tx_slice_operand0,
   output logic [1:0]       tx_slice_operand1,
   output logic             tx_slice_carryflag,
   input  logic [1:0]       rx_slice_result,
   input  logic             rx_slice_carryflag
);

   localparam int unsigned DIGITS = WIDTH / 2;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic [4:0]         op_q, op_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d, zero_q, zero_d, sign_q, sign_d, error_q, error_d;
   logic               accept, arith, run;
   logic [IDX_W:0]     bit_pos;

   assign accept  = rx_start && (state_q != StRun);
   assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign run     = (state_q == StRun);
   assign bit_pos = {idx_q, 1'b0};

   // Next-state: accept/latch, per-digit accumulation, completion flags.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
      error_d  = error_q;
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               a_d      = rx_operand0;
               b_d      = rx_operand1;
               op_d     = rx_what_op;
               idx_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               zero_d   = 1'b0;
               sign_d   = 1'b0;
               error_d  = 1'b0;
               if (!is_onehot5(rx_what_op)) begin
                  // Malformed op: finish immediately, slice never driven.
                  state_d = StDone;
                  error_d = 1'b1;
                  zero_d  = 1'b1;
                  carry_d = 1'b0;
               end else begin
                  state_d = StRun;
                  if (rx_what_op == OP_SUB)      carry_d = 1'b1;
                  else if (rx_what_op == OP_ADD) carry_d = rx_carryflag;
                  else                           carry_d = 1'b0;
               end
            end
         end
         StRun: begin
            result_d[bit_pos +: 2] = rx_slice_result;
            if (arith) carry_d = rx_slice_carryflag;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(DIGITS - 1)) begin
               state_d = StDone;
               cout_d  = arith ? rx_slice_carryflag : 1'b0;
               zero_d  = (result_d == '0);
               sign_d  = result_d[WIDTH-1];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge rx_clk) begin
      if (rx_reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
         error_q  <= error_d;
      end
   end

   // Outputs and slice drive, decoded from registered state only.
   always_comb begin
      tx_ready           = !run;
      tx_done            = (state_q == StDone);
      tx_error           = error_q;
      tx_result          = result_q;
      tx_carryflag       = cout_q;
      tx_zeroflag        = zero_q;
      tx_signflag        = sign_q;
      tx_slice_what_op   = 5'b00000;
      tx_slice_operand0  = 2'b00;
      tx_slice_operand1  = 2'b00;
      tx_slice_carryflag = 1'b0;
      if (run) begin
         // SUB runs as A + ~B + 1 so the borrow chains across digits.
         tx_slice_what_op   = (op_q == OP_SUB) ? OP_ADD : op_q;
         tx_slice_operand0  = a_q[bit_pos +: 2];
         tx_slice_operand1  = (op_q == OP_SUB) ? ~b_q[bit_pos +: 2] : b_q[bit_pos +: 2];
         tx_slice_carryflag = carry_q;
      end
   end

endmodule

// File: tb/tb_alu2_seq.sv
// Self-checking bench for alu2_seq wired to one alu2 slice.
module tb_alu2_seq;
   import alu2_pkg::*;

   localparam int unsigned WIDTH = 16;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             carry;
      logic             zero;
      logic             sign;
      logic             error;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [4:0]       what_op;
   logic [WIDTH-1:0] op0, op1;
   logic             cin;
   logic             ready, done, error, cflag, zflag, sflag;
   logic [WIDTH-1:0] result;
   logic [4:0]       s_op;
   logic [1:0]       s_a, s_b, s_res;
   logic             s_cin, s_cout;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic sub_seen    = 1'b0;
   logic err_win     = 1'b0;
   logic err_drive   = 1'b0;

   always #5 clk = ~clk;

   alu2_seq #(.WIDTH(WIDTH)) dut (
      .rx_clk             (clk),
      .rx_reset           (rst),
      .rx_start           (start),
      .rx_what_op         (what_op),
      .rx_operand0        (op0),
      .rx_operand1        (op1),
      .rx_carryflag       (cin),
      .tx_ready           (ready),
      .tx_done            (done),
      .tx_error           (error),
      .tx_result          (result),
      .tx_carryflag       (cflag),
      .tx_zeroflag        (zflag),
      .tx_signflag        (sflag),
      .tx_slice_what_op   (s_op),
      .tx_slice_operand0  (s_a),
      .tx_slice_operand1  (s_b),
      .tx_slice_carryflag (s_cin),
      .rx_slice_result    (s_res),
      .rx_slice_carryflag (s_cout)
   );

   alu2 slice (
      .what_op   (s_op),
      .operand0  (s_a),
      .operand1  (s_b),
      .carry_in  (s_cin),
      .result    (s_res),
      .carry_out (s_cout)
   );

   always @(negedge clk) begin
      if (s_op == OP_SUB) sub_seen = 1'b1;
      if (err_win && s_op != 5'b00000) err_drive = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic ci);
      exp_t         e;
      logic [WIDTH:0] s;
      e = '0;
      s = '0;
      case (op)
         OP_ADD: s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
         OP_SUB: s = {1'b0, a} + {1'b0, ~b} + 1;
         OP_AND: s = {1'b0, a & b};
         OP_ORR: s = {1'b0, a | b};
         OP_EOR: s = {1'b0, a ^ b};
         default: e.error = 1'b1;
      endcase
      e.result = s[WIDTH-1:0];
      e.carry  = s[WIDTH];
      e.zero   = (s[WIDTH-1:0] == '0);
      e.sign   = s[WIDTH-1];
      return e;
   endfunction

   // Called at a negedge; drives one start cycle and records the expected result.
   task automatic issue(input logic [4:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic ci);
      check("ready_at_issue", 32'(ready), 32'd1);
      what_op = op; op0 = a; op1 = b; cin = ci; start = 1'b1;
      sb.push_back(model(op, a, b, ci));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for tx_done, check latency and pop/compare the result.
   task automatic wait_check(input string tag, input int exp_lat);
      int   lat;
      exp_t e;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_result"}, 32'(result), 32'(e.result));
         check({tag, "_carry"},  32'(cflag),  32'(e.carry));
         check({tag, "_zero"},   32'(zflag),  32'(e.zero));
         check({tag, "_sign"},   32'(sflag),  32'(e.sign));
         check({tag, "_error"},  32'(error),  32'(e.error));
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"},  32'(ready),  32'd1);
      check({tag, "_done"},   32'(done),   32'd0);
      check({tag, "_result"}, 32'(result), 32'd0);
      check({tag, "_flags"},  32'({cflag, zflag, sflag, error}), 32'd0);
      check({tag, "_slice"},  32'({s_op, s_a, s_b, s_cin}), 32'd0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; what_op = '0; op0 = '0; op1 = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
      wait_check("add_wrap", 8);
      issue(OP_SUB, 16'h0005, 16'h0007, 1'b1);
      wait_check("sub_borrow", 8);
      issue(OP_SUB, 16'h0007, 16'h0005, 1'b0);
      wait_check("sub_noborrow", 8);
      issue(OP_ADD, 16'h7FFF, 16'h0000, 1'b1);
      wait_check("add_cin", 8);

      issue(OP_EOR, 16'hA5A5, 16'hFFFF, 1'b1);
      wait_check("xor", 8);
      issue(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1);  // issued in the DONE cycle
      wait_check("and_b2b", 8);
      issue(OP_ORR, 16'h8001, 16'h0100, 1'b0);
      wait_check("or_b2b", 8);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);

      err_win = 1'b1;
      issue(5'b00011, 16'h1234, 16'h5678, 1'b1);
      wait_check("bad_op", 0);
      @(negedge clk);
      issue(5'b00000, 16'hFFFF, 16'hFFFF, 1'b1);
      wait_check("zero_op", 0);
      @(negedge clk);
      err_win = 1'b0;
      check("bad_op_slice_idle", 32'(err_drive), 32'd0);

      issue(OP_ADD, 16'h1111, 16'h2222, 1'b0);
      repeat (3) @(negedge clk);  // now driving digit 3
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("mid_reset");
      void'(sb.pop_back());
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("mid_reset_no_done", 32'(seen), 32'd0);
      issue(OP_ADD, 16'h1234, 16'h1111, 1'b0);
      wait_check("add_after_reset", 8);
      @(negedge clk);

      issue(OP_ADD, 16'h0F0F, 16'h00F1, 1'b0);
      repeat (2) @(negedge clk);
      what_op = OP_SUB; op0 = 16'hDEAD; op1 = 16'hBEEF; cin = 1'b1; start = 1'b1;
      check("ready_in_run", 32'(ready), 32'd0);
      @(negedge clk);
      start = 1'b0;
      wait_check("start_in_run", 5);
      @(negedge clk);

      check("slice_sub_never", 32'(sub_seen), 32'd0);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
